// File: rtl/song_reader_if.sv
// Bus between the song reader, the note ROM, the player controller and the note player.
// Handshake: new_note marks note/duration as freshly issued for one cycle; the note player
// acknowledges with a one-cycle note_done, accepted only while the reader waits on that note.
interface song_reader_if #(
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic                    play;
    logic [1:0]              song;
    logic                    note_done;
    logic [IDX_W+1:0]        rom_addr;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic [NOTE_W-1:0]       note;
    logic [DUR_W-1:0]        duration;
    logic                    new_note;
    logic                    song_done;

    modport master (
        output play, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        input  play, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );
endinterface

// File: rtl/song_reader.sv
// Walks the note ROM of the selected song, issuing one note per note_done acknowledge,
// and pulses song_done at the end-of-song marker or after the last ROM entry.
module song_reader #(
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    song_reader_if.slave        bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        WAIT_NOTE = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              new_note_q, new_note_d;
    logic              song_done_q, song_done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;

    assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = bus.rom_data[DUR_W-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.play) state_d = FETCH;
            end
            FETCH: begin
                if (bus.play) state_d = LATCH;
            end
            LATCH: begin
                // A zero duration is the end marker and is never issued as a note.
                if (rom_dur == '0) begin
                    state_d     = DONE;
                    song_done_d = 1'b1;
                end else begin
                    note_d     = rom_note;
                    dur_d      = rom_dur;
                    new_note_d = 1'b1;
                    state_d    = WAIT_NOTE;
                end
            end
            WAIT_NOTE: begin
                if (bus.note_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = DONE;
                        song_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign bus.rom_addr  = {bus.song, idx_q};
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: per-cycle vector table for a short song plus
// hand-written sequences for pausing, a full 32-note song and reset mid-note.
module tb_song_reader;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_LATCH = 3'd2,
                           S_WAIT = 3'd3, S_DONE = 3'd4;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;
    logic [11:0] rom [0:127];

    int tests  = 0;
    int failed = 0;

    song_reader_if #(.IDX_W(5), .NOTE_W(6), .DUR_W(6)) bus ();

    song_reader #(.IDX_W(5), .NOTE_W(6), .DUR_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: data valid one cycle after the address.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        logic       play;
        logic       nd;
        logic [2:0] st;
        logic       nn;
        logic       sd;
        logic [5:0] note;
        logic [5:0] dur;
        logic [6:0] addr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] s);
        bus.song      = s;
        bus.play      = 1'b0;
        bus.note_done = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic nn,
                            input logic sd, input logic [5:0] note, input logic [5:0] dur,
                            input logic [6:0] addr);
        chk({tag, ".state"},     32'(dbg_state),     32'(st));
        chk({tag, ".new_note"},  32'(bus.new_note),  32'(nn));
        chk({tag, ".song_done"}, 32'(bus.song_done), 32'(sd));
        chk({tag, ".note"},      32'(bus.note),      32'(note));
        chk({tag, ".duration"},  32'(bus.duration),  32'(dur));
        chk({tag, ".rom_addr"},  32'(bus.rom_addr),  32'(addr));
    endtask

    // new_note and song_done must never coincide
    always @(negedge clk) begin
        if (!reset && (bus.new_note === 1'b1 || bus.song_done === 1'b1))
            chk("nn_sd_exclusive", 32'(bus.new_note & bus.song_done), 32'd0);
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        bit seen_sd;

        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        rom[32] = {6'd10, 6'd4};
        rom[33] = {6'd12, 6'd8};
        rom[34] = {6'd5,  6'd0};
        for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'(i + 1)};

        //            play  nd    state    nn    sd    note   dur   addr
        vecs[0]  = '{1'b1, 1'b0, S_IDLE,  1'b0, 1'b0, 6'd0,  6'd0, 7'd32};
        vecs[1]  = '{1'b1, 1'b0, S_FETCH, 1'b0, 1'b0, 6'd0,  6'd0, 7'd32};
        vecs[2]  = '{1'b1, 1'b1, S_LATCH, 1'b0, 1'b0, 6'd0,  6'd0, 7'd32};
        vecs[3]  = '{1'b1, 1'b0, S_WAIT,  1'b1, 1'b0, 6'd10, 6'd4, 7'd32};
        vecs[4]  = '{1'b1, 1'b0, S_WAIT,  1'b0, 1'b0, 6'd10, 6'd4, 7'd32};
        vecs[5]  = '{1'b1, 1'b1, S_WAIT,  1'b0, 1'b0, 6'd10, 6'd4, 7'd32};
        vecs[6]  = '{1'b1, 1'b0, S_FETCH, 1'b0, 1'b0, 6'd10, 6'd4, 7'd33};
        vecs[7]  = '{1'b1, 1'b0, S_LATCH, 1'b0, 1'b0, 6'd10, 6'd4, 7'd33};
        vecs[8]  = '{1'b1, 1'b0, S_WAIT,  1'b1, 1'b0, 6'd12, 6'd8, 7'd33};
        vecs[9]  = '{1'b1, 1'b1, S_WAIT,  1'b0, 1'b0, 6'd12, 6'd8, 7'd33};
        vecs[10] = '{1'b1, 1'b0, S_FETCH, 1'b0, 1'b0, 6'd12, 6'd8, 7'd34};
        vecs[11] = '{1'b1, 1'b0, S_LATCH, 1'b0, 1'b0, 6'd12, 6'd8, 7'd34};
        vecs[12] = '{1'b1, 1'b0, S_DONE,  1'b0, 1'b1, 6'd12, 6'd8, 7'd34};
        vecs[13] = '{1'b1, 1'b1, S_DONE,  1'b0, 1'b0, 6'd12, 6'd8, 7'd34};
        vecs[14] = '{1'b0, 1'b0, S_DONE,  1'b0, 1'b0, 6'd12, 6'd8, 7'd34};
        vecs[15] = '{1'b1, 1'b0, S_DONE,  1'b0, 1'b0, 6'd12, 6'd8, 7'd34};

        // Tests 1-3: song 1, two notes then the end marker
        do_reset(2'd1);
        for (int r = 0; r < 16; r++) begin
            chk_outs($sformatf("vec%0d", r), vecs[r].st, vecs[r].nn, vecs[r].sd,
                     vecs[r].note, vecs[r].dur, vecs[r].addr);
            bus.play      = vecs[r].play;
            bus.note_done = vecs[r].nd;
            tick();
        end
        bus.note_done = 1'b0;

        // Test 4: pause in FETCH for 10 cycles
        do_reset(2'd1);
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("pause%0d.state", i), 32'(dbg_state), 32'(S_FETCH));
            chk($sformatf("pause%0d.new_note", i), 32'(bus.new_note), 32'd0);
        end
        bus.play = 1'b1;
        tick();
        chk("unpause+1.new_note", 32'(bus.new_note), 32'd0);
        tick();
        chk_outs("unpause+2", S_WAIT, 1'b1, 1'b0, 6'd10, 6'd4, 7'd32);

        // Test 6: reset together with note_done while waiting on a note
        reset         = 1'b1;
        bus.note_done = 1'b1;
        tick();
        reset         = 1'b0;
        bus.note_done = 1'b0;
        chk_outs("rst_mid", S_IDLE, 1'b0, 1'b0, 6'd0, 6'd0, 7'd32);
        tick();
        chk("restart+1.new_note", 32'(bus.new_note), 32'd0);
        tick();
        chk("restart+2.new_note", 32'(bus.new_note), 32'd0);
        tick();
        chk_outs("restart+3", S_WAIT, 1'b1, 1'b0, 6'd10, 6'd4, 7'd32);

        // Test 5: song 3, all 32 entries issued, then song_done without wrap
        do_reset(2'd3);
        bus.play = 1'b1;
        seen_sd  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (bus.song_done) seen_sd = 1'b1;
            end while (!bus.new_note && n < 8);
            chk($sformatf("s3_note%0d.latency", i), 32'(n), (i == 0) ? 32'd3 : 32'd2);
            chk($sformatf("s3_note%0d.note", i), 32'(bus.note), 32'(i + 1));
            chk($sformatf("s3_note%0d.duration", i), 32'(bus.duration), 32'(i + 1));
            chk($sformatf("s3_note%0d.rom_addr", i), 32'(bus.rom_addr), 32'(96 + i));
            bus.note_done = 1'b1;
            tick();
            bus.note_done = 1'b0;
        end
        chk("s3_early_song_done", 32'(seen_sd), 32'd0);
        chk_outs("s3_end", S_DONE, 1'b0, 1'b1, 6'd32, 6'd32, 7'd127);
        tick();
        chk_outs("s3_end+1", S_DONE, 1'b0, 1'b0, 6'd32, 6'd32, 7'd127);
        tick();
        chk_outs("s3_end+2", S_DONE, 1'b0, 1'b0, 6'd32, 6'd32, 7'd127);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
